// File: rtl/fp_add2_ieee_pipe_param.sv
// Parametrised IEEE-754 binary adder: combinational add/round core feeding a LATENCY-deep result shift chain.
// Latency: result valid LATENCY cycles after the operands are presented, 1 result/cycle when not stalled.
// Backpressure: astall or (x_valid & ~x_ready) freezes every stage and drops a_ready; nothing is captured while frozen.
//
// Ports:
//   aclk, arst          clock (rising edge), synchronous active-high reset
//   astall              global freeze of all stages
//   a_valid / a_ready   operand handshake; a_{sign,exp,man}, b_{sign,exp,man} operand fields
//   rm                  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4..7 behave as RNE
//   x / x_valid/x_ready packed result {sign, exp, man} and its handshake
//   inflight            number of valid tokens held in the chain
//   xflags              {invalid, div0, overflow, underflow, inexact}, only when FP_ADD2_PIPE_FLAGS_EN is defined
module fp_add2_ieee_pipe_param #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 1
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   astall,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic                   a_sign,
    input  logic [EXP_W-1:0]       a_exp,
    input  logic [MAN_W-1:0]       a_man,
    input  logic                   b_sign,
    input  logic [EXP_W-1:0]       b_exp,
    input  logic [MAN_W-1:0]       b_man,
    input  logic [2:0]             rm,
    output logic [EXP_W+MAN_W:0]   x,
    output logic                   x_valid,
    input  logic                   x_ready,
`ifdef FP_ADD2_PIPE_FLAGS_EN
    output logic [4:0]             xflags,
`endif
    output logic [3:0]             inflight
);

    localparam int W  = 1 + EXP_W + MAN_W;
    // Working significand: hidden bit, stored mantissa, guard, round, sticky.
    localparam int SW = MAN_W + 4;
    // Exponent arithmetic width: room for the carry-out exponent and for shift counts up to SW.
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // ------------------------------------------------------------------
    // Combinational add/round core
    // ------------------------------------------------------------------
    logic                a_nan, b_nan, a_inf, b_inf, inf_inf, a_ge_b;
    logic                big_sign;
    logic [EXP_W-1:0]    big_exp, sm_exp;
    logic [MAN_W-1:0]    big_man, sm_man;
    logic [EW-1:0]       big_e, sm_e, d, dc, lz, sh, ne, fe;
    logic [SW-1:0]       big_x, sm_x, al, n;
    logic [2*SW-1:0]     wide;
    logic [SW:0]         s;
    logic [MAN_W:0]      m;
    logic [MAN_W+1:0]    mr;
    logic [MAN_W-1:0]    fm;
    logic                g, rs, inexact, inc, rne, rtz, rdn, rup, ovf, to_inf;
    logic [W-1:0]        core_res;

    assign a_nan   = (a_exp == EXP_ONES) && (a_man != '0);
    assign b_nan   = (b_exp == EXP_ONES) && (b_man != '0);
    assign a_inf   = (a_exp == EXP_ONES) && (a_man == '0);
    assign b_inf   = (b_exp == EXP_ONES) && (b_man == '0);
    assign inf_inf = a_inf & b_inf & (a_sign ^ b_sign);

    always_comb begin
        // Order by magnitude so the subtraction below never goes negative.
        a_ge_b   = {a_exp, a_man} >= {b_exp, b_man};
        big_sign = a_ge_b ? a_sign : b_sign;
        big_exp  = a_ge_b ? a_exp  : b_exp;
        big_man  = a_ge_b ? a_man  : b_man;
        sm_exp   = a_ge_b ? b_exp  : a_exp;
        sm_man   = a_ge_b ? b_man  : a_man;

        // Subnormals share the scale of exponent 1, only without the hidden bit.
        big_e = (big_exp == '0) ? EW'(1) : {2'b00, big_exp};
        sm_e  = (sm_exp  == '0) ? EW'(1) : {2'b00, sm_exp};
        big_x = {big_exp != '0, big_man, 3'b000};
        sm_x  = {sm_exp  != '0, sm_man,  3'b000};

        // Align the smaller operand; anything shifted past the round bit folds into sticky.
        d    = big_e - sm_e;
        dc   = (d > EW'(SW)) ? EW'(SW) : d;
        wide = {sm_x, {SW{1'b0}}} >> dc;
        al   = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};

        s = (a_sign ^ b_sign) ? ({1'b0, big_x} - {1'b0, al})
                              : ({1'b0, big_x} + {1'b0, al});

        // Leading-zero count of the in-range part; the highest set bit wins.
        lz = EW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (s[i]) lz = EW'(SW - 1 - i);
        end

        if (s[SW]) begin
            sh = '0;
            n  = {s[SW:2], s[1] | s[0]};
            ne = big_e + EW'(1);
        end else begin
            // Never normalise below exponent 1: what is left unnormalised is a subnormal.
            sh = (lz < big_e - EW'(1)) ? lz : big_e - EW'(1);
            n  = s[SW-1:0] << sh;
            ne = big_e - sh;
        end

        rtz = (rm == 3'd1);
        rdn = (rm == 3'd2);
        rup = (rm == 3'd3);
        rne = ~(rtz | rdn | rup);

        m       = n[SW-1:3];
        g       = n[2];
        rs      = n[1] | n[0];
        inexact = g | rs;
        inc     = (rne & g & (rs | m[0])) | (rdn & big_sign & inexact) | (rup & ~big_sign & inexact);
        mr      = {1'b0, m} + {{(MAN_W+1){1'b0}}, inc};

        if (mr[MAN_W+1]) begin
            fm = mr[MAN_W:1];
            fe = ne + EW'(1);
        end else begin
            // A subnormal that rounds up into the hidden bit becomes exponent 1 naturally.
            fm = mr[MAN_W-1:0];
            fe = mr[MAN_W] ? ne : '0;
        end

        ovf    = fe >= {2'b00, EXP_ONES};
        to_inf = rne | (rup & ~big_sign) | (rdn & big_sign);

        if (a_nan | b_nan | inf_inf) begin
            core_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (a_inf | b_inf) begin
            core_res = {a_inf ? a_sign : b_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s == '0) begin
            core_res = {(a_sign & b_sign) | (rdn & (a_sign ^ b_sign)), {(W-1){1'b0}}};
        end else if (ovf) begin
            core_res = to_inf ? {big_sign, EXP_ONES, {MAN_W{1'b0}}}
                              : {big_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else begin
            core_res = {big_sign, fe[EXP_W-1:0], fm};
        end
    end

    // ------------------------------------------------------------------
    // Result chain and flow control
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] vld_q;
    logic [W-1:0]       dat_q [LATENCY];
    logic [3:0]         cnt_q;
    logic               stall, advance, accept, retire;

    assign x       = dat_q[LATENCY-1];
    assign x_valid = vld_q[LATENCY-1];
    assign stall   = astall | (x_valid & ~x_ready);
    assign advance = ~stall;
    assign a_ready = advance;
    assign accept  = a_valid & a_ready;
    assign retire  = x_valid & x_ready & ~astall;
    assign inflight = cnt_q;

    always_ff @(posedge aclk) begin
        if (arst) begin
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) dat_q[k] <= '0;
            cnt_q <= '0;
        end else begin
            // Bubbles shift like tokens; data always follows the core so it stays deterministic.
            if (advance) begin
                vld_q[0] <= a_valid;
                dat_q[0] <= core_res;
                for (int k = 1; k < LATENCY; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    dat_q[k] <= dat_q[k-1];
                end
            end
            case ({accept, retire})
                2'b10:   cnt_q <= cnt_q + 4'd1;
                2'b01:   cnt_q <= cnt_q - 4'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef FP_ADD2_PIPE_FLAGS_EN
    logic       a_snan, b_snan, finite;
    logic [4:0] core_flags;
    logic [4:0] flg_q [LATENCY];

    assign a_snan = a_nan & ~a_man[MAN_W-1];
    assign b_snan = b_nan & ~b_man[MAN_W-1];
    assign finite = ~(a_nan | b_nan | a_inf | b_inf);

    always_comb begin
        core_flags    = '0;
        core_flags[4] = a_snan | b_snan | inf_inf;
        if (finite) begin
            core_flags[2] = ovf;
            // Tininess is judged before rounding: hidden bit still clear after normalisation.
            core_flags[1] = ~n[SW-1] & inexact & ~ovf;
            core_flags[0] = ovf | inexact;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            for (int k = 0; k < LATENCY; k++) flg_q[k] <= '0;
        end else if (advance) begin
            flg_q[0] <= core_flags;
            for (int k = 1; k < LATENCY; k++) flg_q[k] <= flg_q[k-1];
        end
    end

    assign xflags = flg_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_fp_add2_ieee_pipe_param.sv
module tb_fp_add2_ieee_pipe_param;

    logic        aclk = 1'b0;
    logic        arst;
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_man, b_man;
    logic [2:0]  rm;

    logic        av1, ar1, xv1, xr1, st1;
    logic        av3, ar3, xv3, xr3, st3;
    logic        av4, ar4, xv4, xr4, st4;
    logic [31:0] x1, x3, x4;
    logic [3:0]  inf1, inf3, inf4;
`ifdef FP_ADD2_PIPE_FLAGS_EN
    logic [4:0]  fl1, fl3, fl4;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] fvals [10];

    always #5 aclk = ~aclk;

    fp_add2_ieee_pipe_param #(.EXP_W(8), .MAN_W(23), .LATENCY(1)) u1 (
        .aclk(aclk), .arst(arst), .astall(st1), .a_valid(av1), .a_ready(ar1),
        .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
        .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man), .rm(rm),
        .x(x1), .x_valid(xv1), .x_ready(xr1),
`ifdef FP_ADD2_PIPE_FLAGS_EN
        .xflags(fl1),
`endif
        .inflight(inf1));

    fp_add2_ieee_pipe_param #(.EXP_W(8), .MAN_W(23), .LATENCY(3)) u3 (
        .aclk(aclk), .arst(arst), .astall(st3), .a_valid(av3), .a_ready(ar3),
        .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
        .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man), .rm(rm),
        .x(x3), .x_valid(xv3), .x_ready(xr3),
`ifdef FP_ADD2_PIPE_FLAGS_EN
        .xflags(fl3),
`endif
        .inflight(inf3));

    fp_add2_ieee_pipe_param #(.EXP_W(8), .MAN_W(23), .LATENCY(4)) u4 (
        .aclk(aclk), .arst(arst), .astall(st4), .a_valid(av4), .a_ready(ar4),
        .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
        .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man), .rm(rm),
        .x(x4), .x_valid(xv4), .x_ready(xr4),
`ifdef FP_ADD2_PIPE_FLAGS_EN
        .xflags(fl4),
`endif
        .inflight(inf4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        {a_sign, a_exp, a_man} = a;
        {b_sign, b_exp, b_man} = b;
        rm = r;
    endtask

    // One operand pair through the LATENCY=1 instance; result is visible right after the edge.
    task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] r, input logic [31:0] xe, input logic [4:0] fe);
        set_ops(a, b, r);
        av1 = 1'b1;
        tick;
        chk(tag, x1, xe);
`ifdef FP_ADD2_PIPE_FLAGS_EN
        chk({tag, "_flags"}, 32'(fl1), 32'(fe));
`else
        if (fe === 5'h1f) $display("unused flag pattern for %s", tag);
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int sent, got, peak, exp_inf;
        logic hold_prev, xv_prev, acc;
        logic [31:0] x_prev;

        fvals[0] = 32'h00000000; fvals[1] = 32'h3F800000; fvals[2] = 32'h40000000;
        fvals[3] = 32'h40400000; fvals[4] = 32'h40800000; fvals[5] = 32'h40A00000;
        fvals[6] = 32'h40C00000; fvals[7] = 32'h40E00000; fvals[8] = 32'h41000000;
        fvals[9] = 32'h41100000;

        arst = 1'b1;
        set_ops(32'h0, 32'h0, 3'd0);
        av1 = 0; av3 = 0; av4 = 0;
        xr1 = 1; xr3 = 1; xr4 = 1;
        st1 = 0; st3 = 0; st4 = 0;
        tick; tick;

        // Reset state
        chk("rst_x1", x1, 32'h0);
        chk("rst_xv1", 32'(xv1), 0);
        chk("rst_inf1", 32'(inf1), 0);
        chk("rst_ar1", 32'(ar1), 1);
        chk("rst_xv4", 32'(xv4), 0);
        chk("rst_ar4", 32'(ar4), 1);
        arst = 1'b0;

        // LATENCY=1 basic: 1.0 + 2.0
        set_ops(32'h3F800000, 32'h40000000, 3'd0);
        av1 = 1'b1;
        #1 chk("l1_ardy", 32'(ar1), 1);
        tick;
        av1 = 1'b0;
        chk("l1_x", x1, 32'h40400000);
        chk("l1_xv", 32'(xv1), 1);
        chk("l1_inf1", 32'(inf1), 1);
        tick;
        chk("l1_xv_after", 32'(xv1), 0);
        chk("l1_inf0", 32'(inf1), 0);

        // Directed arithmetic vectors
        vec("ovf_rne",   32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 32'h7F800000, 5'b00101);
        vec("ovf_rtz",   32'h7F7FFFFF, 32'h7F7FFFFF, 3'd1, 32'h7F7FFFFF, 5'b00101);
        vec("ovf_rdn",   32'h7F7FFFFF, 32'h7F7FFFFF, 3'd2, 32'h7F7FFFFF, 5'b00101);
        vec("ovf_rup",   32'h7F7FFFFF, 32'h7F7FFFFF, 3'd3, 32'h7F800000, 5'b00101);
        vec("novf_rup",  32'hFF7FFFFF, 32'hFF7FFFFF, 3'd3, 32'hFF7FFFFF, 5'b00101);
        vec("novf_rdn",  32'hFF7FFFFF, 32'hFF7FFFFF, 3'd2, 32'hFF800000, 5'b00101);
        vec("ovf_round", 32'h7F7FFFFF, 32'h73000000, 3'd0, 32'h7F800000, 5'b00101);
        vec("inf_inf",   32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 5'b10000);
        vec("inf_fin",   32'h7F800000, 32'h3F800000, 3'd0, 32'h7F800000, 5'b00000);
        vec("qnan",      32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000);
        vec("snan",      32'h7F800001, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000);
        vec("zero_rdn",  32'h3F800000, 32'hBF800000, 3'd2, 32'h80000000, 5'b00000);
        vec("zero_rne",  32'h3F800000, 32'hBF800000, 3'd0, 32'h00000000, 5'b00000);
        vec("negzero",   32'h80000000, 32'h80000000, 3'd0, 32'h80000000, 5'b00000);
        vec("sub_exact", 32'h00800000, 32'h80000001, 3'd0, 32'h007FFFFF, 5'b00000);
        vec("sub_min",   32'h00800001, 32'h80800000, 3'd0, 32'h00000001, 5'b00000);
        vec("sub_sub",   32'h00000001, 32'h00000001, 3'd0, 32'h00000002, 5'b00000);
        vec("sub_norm",  32'h00400000, 32'h00400000, 3'd0, 32'h00800000, 5'b00000);
        vec("tiny_rne",  32'h3F800000, 32'h30800000, 3'd0, 32'h3F800000, 5'b00001);
        vec("tiny_rup",  32'h3F800000, 32'h30800000, 3'd3, 32'h3F800001, 5'b00001);
        vec("tie_even",  32'h3F800000, 32'h33800000, 3'd0, 32'h3F800000, 5'b00001);
        vec("tie_odd",   32'h3F800001, 32'h33800000, 3'd0, 32'h3F800002, 5'b00001);
        vec("neg_rdn",   32'hBF800000, 32'hB0800000, 3'd2, 32'hBF800001, 5'b00001);
        vec("neg_rup",   32'hBF800000, 32'hB0800000, 3'd3, 32'hBF800000, 5'b00001);
        vec("diff_norm", 32'h40000000, 32'hBF800000, 3'd0, 32'h3F800000, 5'b00000);
        vec("mixed",     32'h3FC00000, 32'h40100000, 3'd0, 32'h40700000, 5'b00000);
        vec("neg_res",   32'hC0000000, 32'h3F800000, 3'd0, 32'hBF800000, 5'b00000);
        av1 = 1'b0;
        tick;

        // LATENCY=4 stream of 8 back-to-back pairs
        peak = 0;
        for (int j = 1; j <= 12; j++) begin
            if (j <= 8) begin
                set_ops(fvals[j], fvals[1], 3'd0);
                av4 = 1'b1;
                #1 chk("st_ardy", 32'(ar4), 1);
            end else begin
                av4 = 1'b0;
            end
            tick;
            chk("st_xv", 32'(xv4), 32'((j >= 4) && (j <= 11)));
            if ((j >= 4) && (j <= 11)) chk("st_x", x4, fvals[j-2]);
            exp_inf = ((j < 8) ? j : 8) - ((j > 4) ? (j - 4) : 0);
            chk("st_inf", 32'(inf4), 32'(exp_inf));
            if (int'(inf4) > peak) peak = int'(inf4);
        end
        chk("st_peak", 32'(peak), 4);

        // LATENCY=3 back-pressure and astall
        sent = 0; got = 0; hold_prev = 1'b0; xv_prev = 1'b0; x_prev = '0;
        for (int c = 0; c < 30; c++) begin
            xr3 = !((c >= 3) && (c <= 7));
            st3 = (c == 10) || (c == 11) || (c == 14);
            if (sent < 6) begin
                set_ops(fvals[sent+1], fvals[1], 3'd0);
                av3 = 1'b1;
            end else begin
                av3 = 1'b0;
            end
            #1;
            if (hold_prev) begin
                chk("bp_hold_x", x3, x_prev);
                chk("bp_hold_v", 32'(xv3), 32'(xv_prev));
            end
            if (st3 || (xv3 && !xr3)) chk("bp_ardy", 32'(ar3), 0);
            acc = av3 & ar3;
            if (xv3 && xr3 && !st3) begin
                if (got < 6) chk("bp_data", x3, fvals[got+2]);
                got++;
            end
            hold_prev = st3 | (xv3 & ~xr3);
            xv_prev = xv3;
            x_prev = x3;
            tick;
            if (acc) sent++;
        end
        chk("bp_got", 32'(got), 6);
        chk("bp_sent", 32'(sent), 6);
        chk("bp_inf", 32'(inf3), 0);
        xr3 = 1'b1; st3 = 1'b0; av3 = 1'b0;

        // Reset with 3 tokens in flight (LATENCY=4); reset wins over astall and a_valid
        for (int i = 0; i < 3; i++) begin
            set_ops(fvals[i+1], fvals[1], 3'd0);
            av4 = 1'b1;
            tick;
        end
        chk("mr_inf3", 32'(inf4), 3);
        chk("mr_xv_pre", 32'(xv4), 0);
        arst = 1'b1;
        st4 = 1'b1;
        tick;
        chk("mr_xv", 32'(xv4), 0);
        chk("mr_x", x4, 32'h0);
        chk("mr_inf", 32'(inf4), 0);
        arst = 1'b0;
        st4 = 1'b0;
        av4 = 1'b0;
        #1 chk("mr_ardy", 32'(ar4), 1);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("mr_no_stale", 32'(xv4), 0);
            chk("mr_inf_stay", 32'(inf4), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add2_ieee_pipe_param.md
Name: fp_add2_ieee_pipe_param

Overview:
- Parametrised pipelined IEEE-754 binary floating-point adder. Generalises the fixed E8/M23, single-register stall-only adder wrapper.
- Exponent width, mantissa width and pipeline depth are configurable. Adds valid/ready flow control, an in-flight counter and synchronous reset.
- Arithmetic is done by a combinational core at the pipeline input. Result registers are a LATENCY-deep shift chain behind it.
- Sits in sfu/cachelib and feeds SFU datapaths that need back-pressure.

Parameters:
- EXP_W, 8, exponent width in bits (4..11)
- MAN_W, 23, stored mantissa width in bits (3..52)
- LATENCY, 1, number of result register stages (1..8)
- Derived: W = 1+EXP_W+MAN_W, the packed result width.

Ports:
- aclk  in  1  clock, rising edge
- arst  in  1  synchronous, active-high reset
- astall  in  1  global stall: freezes all stages while high
- a_valid  in  1  operand pair valid
- a_ready  out  1  block can accept an operand pair this cycle
- a_sign, a_exp, a_man  in  1/EXP_W/MAN_W  operand A fields
- b_sign, b_exp, b_man  in  1/EXP_W/MAN_W  operand B fields
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN (toward -inf), 3 RUP (toward +inf); 4..7 treated as RNE
- x  out  W  result {sign, exp, man}
- x_valid  out  1  result valid
- x_ready  in  1  downstream accepts the result
- inflight  out  4  count of valid tokens in the pipeline (0..LATENCY)

Behaviour:
- Arithmetic: combinational IEEE add, IEEE rounding per rm.
  - Subnormal inputs and outputs are supported.
  - Any NaN input gives canonical qNaN: sign 0, exp all-ones, man MSB=1, rest 0.
  - +inf + -inf gives canonical qNaN.
  - Exact zero sum: sign is 1 only when rm=RDN; otherwise +0. When both operands are -0, the result is -0.
  - Overflow gives inf under RNE, or under a mode rounding away from zero for that sign. Otherwise it gives max finite.
- Pipeline: stage k holds {valid_k, data_k}, k=1..LATENCY. Stage 1 captures core(a,b,rm) and a_valid.
- Definitions:
  - stall = astall | (x_valid & ~x_ready)
  - advance = ~stall
  - a_ready = advance
- On advance, every stage shifts by one. Bubbles (valid=0) shift too; they are not compressed.
- On stall, all stages hold. a_ready=0, and an operand offered with a_valid=1 is not captured.
- x = data_LATENCY and x_valid = valid_LATENCY. Both are stable while x_valid & ~x_ready.
- Latency: an operand accepted at edge t (a_valid & a_ready) appears with x_valid=1 after edge t+LATENCY-1, i.e. LATENCY cycles after being presented, given no stalls.
- Throughput: 1 per cycle while x_ready=1 and astall=0.
- Data registers update on advance regardless of valid. A bubble's data is don't-care, but it must still be deterministic.
- inflight: sum of valid_k, registered.
  - Increments on accept without retire.
  - Decrements on retire (x_valid & x_ready & ~astall) without accept.
  - Unchanged when both or neither occur.
  - Never exceeds LATENCY.
- Reset (arst=1 at an edge): all valid_k=0, all data_k=0, inflight=0. Reset takes priority over astall.
  - Outputs after reset: x=0, x_valid=0.
  - a_ready=1 is combinational and follows from x_valid=0 and astall=0.
  - Reset mid-operation discards all in-flight tokens. No result is emitted for them.
- During the reset cycle itself, a_valid is ignored.

Optional Feature:
- Macro: FP_ADD2_PIPE_FLAGS_EN.
- When defined, adds output port xflags [4:0] = {invalid, div0(always 0), overflow, underflow, inexact}, pipelined alongside data and qualified by x_valid.
  - invalid: a signalling NaN input, or inf minus inf.
  - overflow: finite inputs with an inf or max-finite rounded result.
  - underflow: tiny and inexact.
  - inexact: any rounding loss.
  - Reset value 0.
- When not defined, the port and its registers do not exist. The data path is otherwise identical.

Test Plan:
- E8/M23, LATENCY=1: 0x3F800000 + 0x40000000, rm=0 -> x=0x40400000, x_valid one cycle later, inflight 1 then 0.
- LATENCY=4, x_ready=1: stream 8 back-to-back pairs -> 8 results in order, first at cycle 4, one per cycle; inflight peaks at 4.
- LATENCY=3: hold x_ready=0 while x_valid=1 for 5 cycles -> x stable and a_ready=0. Then release -> no loss or duplication. Separately, astall pulses freeze the pipe identically.
- 0x7F7FFFFF + 0x7F7FFFFF: rm=0 -> 0x7F800000; rm=1 -> 0x7F7FFFFF. 0x7F800000 + 0xFF800000 -> 0x7FC00000. 0x3F800000 + 0xBF800000 with rm=2 -> 0x80000000.
- Reset with 3 tokens in flight (LATENCY=4) -> next cycle x_valid=0, x=0, inflight=0. No stale results appear afterwards.
- FLAGS_EN: 0x00000001 * 0.5-style underflow case 0x00800000 + 0x80000001 -> exact subnormal 0x007FFFFF, xflags=0. 1.0 + 2^-30 -> 0x3F800000, inexact=1.
